// File: rtl/prio_force_reg_pkg.sv
// Shared types and helpers for the prioritised force register.
//   pf_state_t : IDLE / FORCED / RELEASE register states
//   idx_w()    : width of a request index, never less than one bit
package prio_force_pkg;

  typedef enum logic [1:0] {IDLE, FORCED, RELEASE} pf_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_force_reg_if.sv
// Request/response bundle for prio_force_reg.
//   master : drives force_req, d, en; observes q, forced, force_idx, force_events
//   slave  : the register side of the same signals
interface prio_force_reg_if #(
  parameter int WIDTH     = 2,
  parameter int NUM_FORCE = 3,
  parameter int CNT_W     = 8
);
  localparam int IW = prio_force_pkg::idx_w(NUM_FORCE);

  logic [NUM_FORCE-1:0] force_req;
  logic [WIDTH-1:0]     d;
  logic                 en;
  logic [WIDTH-1:0]     q;
  logic                 forced;
  logic [IW-1:0]        force_idx;
  logic [CNT_W-1:0]     force_events;

  modport master (output force_req, d, en,
                  input  q, forced, force_idx, force_events);
  modport slave  (input  force_req, d, en,
                  output q, forced, force_idx, force_events);
endinterface

// File: rtl/prio_force_reg_prio_enc_lsb.sv
// Lowest-index-first priority encoder (combinational).
//   req   : request vector, bit 0 wins
//   valid : any request set
//   idx   : index of the winning request (0 when none)
module prio_enc_lsb #(
  parameter int N  = 3,
  parameter int IW = prio_force_pkg::idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/prio_force_reg.sv
// Register with NUM_FORCE prioritised force sources, release hold-off and a
// saturating count of entries into FORCED.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus        : force_req/d/en in; q/forced/force_idx/force_events out
module prio_force_reg
  import prio_force_pkg::*;
#(
  parameter int                         WIDTH       = 2,
  parameter int                         NUM_FORCE   = 3,
  parameter logic [NUM_FORCE*WIDTH-1:0] FORCE_VALS  = {2'd0, 2'd1, 2'd2},
  parameter logic [WIDTH-1:0]           RESET_VAL   = '0,
  parameter int                         RELEASE_CYC = 2,
  parameter int                         CNT_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  prio_force_reg_if.slave bus
);
  localparam int IW = idx_w(NUM_FORCE);
  localparam int RW = (RELEASE_CYC > 0) ? $clog2(RELEASE_CYC + 1) : 1;
  localparam logic [RW-1:0] RCNT_INIT = RW'((RELEASE_CYC > 0) ? RELEASE_CYC - 1 : 0);

  pf_state_t        st, st_nxt;
  logic [WIDTH-1:0] q_r, q_nxt, fval;
  logic [IW-1:0]    idx_r, idx_nxt, w;
  logic [RW-1:0]    rcnt, rcnt_nxt;
  logic [CNT_W-1:0] evt;
  logic             evt_inc, any_force;

  prio_enc_lsb #(.N(NUM_FORCE), .IW(IW)) u_enc (
    .req   (bus.force_req),
    .valid (any_force),
    .idx   (w)
  );

  always_comb begin
    st_nxt   = st;
    q_nxt    = q_r;
    idx_nxt  = idx_r;
    rcnt_nxt = rcnt;
    evt_inc  = 1'b0;
    fval     = FORCE_VALS[int'(w)*WIDTH +: WIDTH];
    unique case (st)
      IDLE: begin
        if (any_force) begin
          q_nxt   = fval;
          idx_nxt = w;
          st_nxt  = FORCED;
          evt_inc = 1'b1;
        end else if (bus.en) begin
          q_nxt = bus.d;
        end
      end
      FORCED: begin
        // Pre-emption in either direction stays in FORCED without counting.
        if (any_force) begin
          q_nxt   = fval;
          idx_nxt = w;
        end else if (RELEASE_CYC == 0) begin
          st_nxt = IDLE;
          if (bus.en) q_nxt = bus.d;
        end else begin
          st_nxt   = RELEASE;
          rcnt_nxt = RCNT_INIT;
        end
      end
      RELEASE: begin
        if (any_force) begin
          q_nxt   = fval;
          idx_nxt = w;
          st_nxt  = FORCED;
          evt_inc = 1'b1;
        end else if (rcnt == '0) begin
          st_nxt = IDLE;
          if (bus.en) q_nxt = bus.d;
        end else begin
          rcnt_nxt = rcnt - 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      q_r   <= RESET_VAL;
      idx_r <= '0;
      rcnt  <= '0;
      evt   <= '0;
    end else begin
      st    <= st_nxt;
      q_r   <= q_nxt;
      idx_r <= idx_nxt;
      rcnt  <= rcnt_nxt;
      if (evt_inc && evt != '1) evt <= evt + 1'b1;
    end
  end

  assign bus.q            = q_r;
  assign bus.forced       = (st != IDLE);
  assign bus.force_idx    = idx_r;
  assign bus.force_events = evt;
endmodule

// File: tb/tb_prio_force_reg.sv
// Directed bench for prio_force_reg: default config (a), RELEASE_CYC=0 (b),
// CNT_W=2 (c). Inputs change 1ns after a rising edge; outputs are checked there.
module tb_prio_force_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prio_force_reg_if #(.WIDTH(2), .NUM_FORCE(3), .CNT_W(8)) ifa ();
  prio_force_reg_if #(.WIDTH(2), .NUM_FORCE(3), .CNT_W(8)) ifb ();
  prio_force_reg_if #(.WIDTH(2), .NUM_FORCE(3), .CNT_W(2)) ifc ();

  prio_force_reg #(.RELEASE_CYC(2), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  prio_force_reg #(.RELEASE_CYC(0), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  prio_force_reg #(.RELEASE_CYC(2), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int q, input int f, input int idx, input int ev);
    chk({tag, ".q"}, 32'(ifa.q), q);
    chk({tag, ".forced"}, 32'(ifa.forced), f);
    chk({tag, ".idx"}, 32'(ifa.force_idx), idx);
    chk({tag, ".events"}, 32'(ifa.force_events), ev);
  endtask

  initial begin
    ifa.force_req = '0; ifa.d = '0; ifa.en = 1'b0;
    ifb.force_req = '0; ifb.d = '0; ifb.en = 1'b0;
    ifc.force_req = '0; ifc.d = '0; ifc.en = 1'b0;

    // Reset state
    step(2);
    chk_a("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Data path
    ifa.en = 1'b1; ifa.d = 2'd3; step();
    chk_a("load", 3, 0, 0, 0);
    ifa.en = 1'b0; ifa.d = 2'd1; step();
    chk("hold.q", 32'(ifa.q), 3);

    // Priority; en/d must be ignored while forced
    ifa.en = 1'b1; ifa.d = 2'd3;
    ifa.force_req = 3'b110; step();
    chk_a("prio110", 1, 1, 1, 1);
    ifa.force_req = 3'b111; step();
    chk_a("prio111", 2, 1, 0, 1);
    ifa.force_req = 3'b100; step();
    chk_a("prio100", 0, 1, 2, 1);

    // Release hold-off: two held edges, then d loads
    ifa.force_req = 3'b000; step();
    chk_a("rel1", 0, 1, 2, 1);
    step();
    chk_a("rel2", 0, 1, 2, 1);
    step();
    chk_a("rel3", 3, 0, 2, 1);

    // Re-force during RELEASE counts a new entry
    ifa.force_req = 3'b010; step();
    chk_a("force2", 1, 1, 1, 2);
    ifa.force_req = 3'b000; step();
    chk_a("rel_a", 1, 1, 1, 2);
    ifa.force_req = 3'b010; step();
    chk_a("reforce", 1, 1, 1, 3);
    // Lower-priority pre-emption, no increment
    ifa.force_req = 3'b100; step();
    chk_a("preempt_lo", 0, 1, 2, 3);
    ifa.force_req = 3'b001; step();
    chk_a("preempt_hi", 2, 1, 0, 3);

    // Async reset mid-FORCED, no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0);
    // force held across reset release: first edge enters FORCED and counts 1
    ifa.force_req = 3'b010;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk_a("force_thru_rst", 1, 1, 1, 1);
    ifa.force_req = 3'b000; ifa.en = 1'b0;

    // RELEASE_CYC=0: q loads d on the first no-force edge
    ifb.force_req = 3'b001; step();
    chk("b.force.q", 32'(ifb.q), 2);
    chk("b.force.forced", 32'(ifb.forced), 1);
    ifb.force_req = 3'b000; ifb.en = 1'b1; ifb.d = 2'd3; step();
    chk("b.rel.q", 32'(ifb.q), 3);
    chk("b.rel.forced", 32'(ifb.forced), 0);
    ifb.force_req = 3'b010; step();
    chk("b.force2.q", 32'(ifb.q), 1);
    ifb.force_req = 3'b000; ifb.en = 1'b0; step();
    chk("b.rel_noen.q", 32'(ifb.q), 1);
    chk("b.rel_noen.forced", 32'(ifb.forced), 0);

    // CNT_W=2 saturation over five force/release cycles
    for (int k = 1; k <= 5; k++) begin
      ifc.force_req = 3'b001; step();
      chk($sformatf("c.events%0d", k), 32'(ifc.force_events), (k < 3) ? k : 3);
      ifc.force_req = 3'b000; step(3);
      chk($sformatf("c.idle%0d", k), 32'(ifc.forced), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prio_force_reg.md
Name: prio_force_reg

Overview:
- Parametrised register with N prioritised force sources. Each source overrides the data path with its own constant value.
- Generalises the fixed A/B/C priority-set register: arbitrary width, force count and per-force value.
- Adds a release hold-off state machine and a force-event counter.
- Sits at control/status boundaries where several override requests must drive one register deterministically.

Parameters:
- WIDTH, 2: data/register width in bits.
- NUM_FORCE, 3: number of force request inputs; index 0 has the highest priority.
- FORCE_VALS, {2'd0,2'd1,2'd2}: packed NUM_FORCE*WIDTH vector; slice [i*WIDTH +: WIDTH] is the value forced by request i (default: req0->2, req1->1, req2->0).
- RESET_VAL, 0: value of q under reset.
- RELEASE_CYC, 2: edges q is held after all forces drop; 0 means no hold-off.
- CNT_W, 8: width of the saturating force-event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- force_req  in  NUM_FORCE  force requests, level-sensitive, sampled at clk.
- d  in  WIDTH  data input.
- en  in  1  data load enable; honoured only in IDLE.
- q  out  WIDTH  registered output.
- forced  out  1  1 when state is FORCED or RELEASE.
- force_idx  out  max(1,$clog2(NUM_FORCE))  index of the last winning force request.
- force_events  out  CNT_W  saturating count of entries into FORCED.

Behaviour:
- Reset (rst_n=0, takes effect immediately): q=RESET_VAL, state=IDLE, forced=0, force_idx=0, force_events=0, release counter=0.
- All outputs are registered. Effects appear after the sampling edge: 1-cycle latency.
- Winner: w = lowest set index of force_req, recomputed combinationally every cycle. any_force = |force_req.
- Register states: IDLE, FORCED, RELEASE.
- IDLE:
  - any_force -> q<=FORCE_VALS[w], force_idx<=w, state->FORCED, force_events++ (saturating).
  - else en -> q<=d; otherwise q holds.
- FORCED:
  - any_force -> q<=FORCE_VALS[w], force_idx<=w. Pre-emption works in both directions (higher or lower priority), with no event increment.
  - else RELEASE_CYC==0 -> state->IDLE and the IDLE data rule applies on the same edge (q<=d if en).
  - else state->RELEASE, rcnt<=RELEASE_CYC-1, q holds.
- RELEASE:
  - any_force -> state->FORCED, q<=FORCE_VALS[w], force_idx<=w, force_events++.
  - else rcnt==0 -> state->IDLE, q<=d if en, else hold.
  - else rcnt--, q holds.
- Net effect: q is held for exactly RELEASE_CYC edges after the first no-force edge. At the next edge q may load d.
- en is ignored in FORCED and RELEASE; d is never captured there.
- forced is 1 in FORCED and RELEASE, deasserts on the edge entering IDLE. force_idx holds its last value in IDLE.
- force_events saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Reset mid-FORCED/RELEASE: immediate return to reset values. After release, the first edge follows IDLE rules.
- force_req held continuously across reset deassertion: the first edge enters FORCED and counts 1.
- NUM_FORCE==1: force_idx is constant 0.

Decomposition:
- Package prio_force_pkg holds:
  - typedef enum logic [1:0] {IDLE, FORCED, RELEASE} pf_state_t.
  - a localparam helper computing the index width.
- One sub-module, prio_enc_lsb: parametric lowest-index-first priority encoder with outputs valid and idx. It is combinational and reused by other arbitration blocks.
- Release counter width: max(1,$clog2(RELEASE_CYC+1)), kept inside prio_force_reg.

Test Plan:
1. Reset then data path: rst_n low->high, en=1, d=3 -> q=3 after 1 edge, forced=0. With en=0 and d=1, q stays 3.
2. Priority: force_req=3'b110 -> q=1, force_idx=1, force_events=1. Then force_req=3'b111 -> q=2, force_idx=0, force_events still 1.
3. Release hold-off (RELEASE_CYC=2): force_req 3'b100 drops to 0, en=1, d=3 -> q=0 for 2 edges with forced=1. On the 3rd edge q=3 and forced=0.
4. Re-force during RELEASE: drop the force, then assert force_req=3'b010 on the next edge -> q=1, state FORCED, force_events increments. Also run RELEASE_CYC=0: q=d on the first no-force edge.
5. Async reset mid-FORCED: assert rst_n=0 between edges -> q=0, forced=0, force_events=0 immediately, without a clock edge.
6. Counter saturation (CNT_W=2): 5 force/release cycles -> force_events=3 after the 3rd entry and stays 3.
